s32x_sh_bus_arb: RTL

- Parametrised arbiter for N SH-2 masters sharing one external bus: SDRAM port plus the 32X system interface.
- Generalises the fixed two-CPU BRLS/BGR cross-wiring into an N-master arbiter.
- Selectable fixed-priority or round-robin mode, optional hold-time limit, one dead cycle at handover.
- Per-master wait generation: owner sees merged SDRAM/interface wait; parked requesters are stalled.
- Sits between the SH7604 instances and the SDRAM/interface mux in the 32X top level.

---
 rtl/s32x_sh_bus_arb_pkg.sv | 24 ++
 rtl/s32x_sh_bus_arb_pick.sv | 32 +++
 rtl/s32x_sh_bus_arb.sv | 110 +++++++++++
 3 files changed

// File: rtl/s32x_sh_bus_arb_pkg.sv
// rtl/s32x_sh_bus_arb_pkg.sv - shared types and helpers for the SH-2 bus arbiter
package s32x_sh_bus_arb_pkg;

    typedef enum logic [1:0] {
        OWNED     = 2'd0,
        RELEASING = 2'd1,
        HANDOVER  = 2'd2
    } arb_state_t;

    localparam int MAX_MASTERS = 8;

    // First set bit of req scanning upward from ptr+1 with wrap over n masters; ptr itself is seen last.
    function automatic logic [2:0] next_rr(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [2:0] idx;
        next_rr = ptr;
        for (int k = MAX_MASTERS; k >= 1; k--) begin
            if (k <= n) begin
                idx = 3'((int'(ptr) + k) % n);
                if (req[idx]) next_rr = idx;
            end
        end
    endfunction

endpackage

// File: rtl/s32x_sh_bus_arb_pick.sv
// rtl/s32x_sh_bus_arb_pick.sv - combinational winner selection among non-owner requesters
module s32x_arb_pick
    import s32x_sh_bus_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int OW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [OW-1:0] owner,
    input  logic          rr_mode,
    output logic [OW-1:0] idx,
    output logic          valid
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] cand;

    always_comb begin
        cand  = req & ~(ONE << owner);
        valid = |cand;
        idx   = '0;
        if (rr_mode) begin
            idx = OW'(next_rr(8'(cand), 3'(owner), N));
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (cand[i]) idx = OW'(i);
            end
        end
    end

endmodule

// File: rtl/s32x_sh_bus_arb.sv
// rtl/s32x_sh_bus_arb.sv - N-master SH-2 external bus arbiter with release handshake and wait merge
module s32x_sh_bus_arb
    import s32x_sh_bus_arb_pkg::*;
#(
    parameter int  N_MASTERS   = 2,
    parameter int  RR_MODE     = 0,
    parameter int  MAX_HOLD    = 0,
    parameter int  PARK_MASTER = 0,
    localparam int OW          = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE_R,
    input  logic [N_MASTERS-1:0] REQ,
    input  logic [N_MASTERS-1:0] BUSY,
    input  logic [N_MASTERS-1:0] LOCK,
    input  logic                 SDR_WAIT,
    input  logic                 IF_WAIT_N,
    output logic [N_MASTERS-1:0] GNT,
    output logic [OW-1:0]        OWNER,
    output logic [N_MASTERS-1:0] RELEASE_REQ,
    output logic [N_MASTERS-1:0] WAIT_N
);

    localparam int                 HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0]      HOLD_LIM = HW'(MAX_HOLD);
    localparam logic [OW-1:0]      PARK     = OW'(PARK_MASTER);
    localparam logic [N_MASTERS-1:0] ONE    = {{(N_MASTERS-1){1'b0}}, 1'b1};

    arb_state_t             state_q, state_d;
    logic [N_MASTERS-1:0]   gnt_q, gnt_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [OW-1:0]          next_q, next_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [OW-1:0]          pick_idx;
    logic                   pick_valid;

    // The owner index doubles as the round-robin pointer: the scan always starts after it.
    s32x_arb_pick #(
        .N  (N_MASTERS),
        .OW (OW)
    ) u_pick (
        .req     (REQ),
        .owner   (owner_q),
        .rr_mode (RR_MODE != 0),
        .idx     (pick_idx),
        .valid   (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        next_d  = next_q;
        hold_d  = hold_q;
        if (CE_R) begin
            case (state_q)
                OWNED: begin
                    if (pick_valid) begin
                        if (hold_q != HOLD_LIM) hold_d = hold_q + HW'(1);
                        if (!REQ[owner_q] ||
                            (RR_MODE == 0 && pick_idx < owner_q) ||
                            (MAX_HOLD != 0 && hold_q == HOLD_LIM))
                            state_d = RELEASING;
                    end
                end
                RELEASING: begin
                    // Winner is chosen here, so late higher-priority requests still win.
                    if (!pick_valid) begin
                        state_d = OWNED;
                    end else if (!BUSY[owner_q] && !LOCK[owner_q]) begin
                        gnt_d   = '0;
                        next_d  = pick_idx;
                        state_d = HANDOVER;
                    end
                end
                HANDOVER: begin
                    gnt_d   = ONE << next_q;
                    owner_d = next_q;
                    hold_d  = '0;
                    state_d = OWNED;
                end
                default: state_d = OWNED;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= OWNED;
            gnt_q   <= ONE << PARK;
            owner_q <= PARK;
            next_q  <= PARK;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            next_q  <= next_d;
            hold_q  <= hold_d;
        end
    end

    assign GNT         = gnt_q;
    assign OWNER       = owner_q;
    assign RELEASE_REQ = (state_q == RELEASING) ? (ONE << owner_q) : '0;
    // Owner sees the merged external wait; a parked requester is stalled; everyone else runs free.
    assign WAIT_N      = (gnt_q & {N_MASTERS{IF_WAIT_N & ~SDR_WAIT}}) | (~gnt_q & ~REQ);

endmodule
